// File: rtl/nrs_cmplx_mult_bank_pkg.sv
// ---------------------------------------------------------------------------
// nb_iot_ce_pkg
// Shared constants and types for the NB-IoT channel-estimation datapath.
//   CE_WIDTH_R_I        : signed width of received I/Q samples
//   CE_PILOT_FLOAT_BITS : fractional bits of the pilot magnitude constant
//   INV_SQRT2           : 1/sqrt(2) in unsigned Q0.CE_PILOT_FLOAT_BITS (1448)
//   sample_t            : signed received sample
//   pilot_sign_t        : per-axis QPSK pilot sign encoding
// ---------------------------------------------------------------------------
package nb_iot_ce_pkg;

    localparam int CE_WIDTH_R_I        = 16;
    localparam int CE_PILOT_FLOAT_BITS = 11;

    localparam logic [CE_PILOT_FLOAT_BITS-1:0] INV_SQRT2 = 11'b10110101000;

    typedef logic signed [CE_WIDTH_R_I-1:0] sample_t;

    // Pilot bit 0 means +VALUE on that axis, 1 means -VALUE.
    typedef enum logic {
        SIGN_POS = 1'b0,
        SIGN_NEG = 1'b1
    } pilot_sign_t;

endpackage

// File: rtl/nrs_cmplx_mult_bank_sign_mac.sv
// ---------------------------------------------------------------------------
// cmplx_sign_mac
// Two-stage datapath computing rx * conj(pilot) for a QPSK pilot of
// magnitude VALUE per axis.
//   Stage 1 (registered, on en): sign-controlled add/sub of rx_r/rx_i.
//   Stage 2 (combinational from stage-1 regs): scale by VALUE and drop
//   PILOT_FLOAT_BITS fraction bits; the caller registers the result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              capture rx_r/rx_i/nrs_r/nrs_i/wr_addr this edge
//   wr_addr         destination entry, carried alongside the data
//   rx_r, rx_i      signed received sample
//   nrs_r, nrs_i    pilot sign per axis (0 = +, 1 = -)
//   out_valid       stage-1 holds a sample (stage-2 result is meaningful)
//   out_addr        entry address for the stage-2 result
//   out_r, out_i    scaled result, WIDTH_R_I+1 signed
// Configuration macro: CMPLX_MULT_ROUND_EN selects round-half-up instead of
// floor when dropping the fraction bits.
// ---------------------------------------------------------------------------
module cmplx_sign_mac
    import nb_iot_ce_pkg::*;
#(
    parameter int                            WIDTH_R_I        = CE_WIDTH_R_I,
    parameter int                            PILOT_FLOAT_BITS = CE_PILOT_FLOAT_BITS,
    parameter logic [PILOT_FLOAT_BITS-1:0]   VALUE            = INV_SQRT2,
    parameter int                            ADDR_W           = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic signed [WIDTH_R_I-1:0] rx_r,
    input  logic signed [WIDTH_R_I-1:0] rx_i,
    input  logic                        nrs_r,
    input  logic                        nrs_i,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           out_addr,
    output logic signed [WIDTH_R_I:0]   out_r,
    output logic signed [WIDTH_R_I:0]   out_i
);

    // Two extra bits: (-2^(W-1)) + (-2^(W-1)) negated is +2^W, which needs
    // W+2 signed bits.
    localparam int SW = WIDTH_R_I + 2;
    // |sum| <= 2^W and VALUE < 2^F, so product plus rounding constant stays
    // below 2^(W+F) and fits W+F+1 signed bits.
    localparam int PW = WIDTH_R_I + PILOT_FLOAT_BITS + 1;

    localparam logic signed [PW-1:0] SCALE = PW'({1'b0, VALUE});

    pilot_sign_t          sgn_r;
    pilot_sign_t          sgn_i;
    logic signed [SW-1:0] xr;
    logic signed [SW-1:0] xi;
    logic signed [SW-1:0] term_a;
    logic signed [SW-1:0] term_b;
    logic signed [SW-1:0] term_c;
    logic signed [SW-1:0] term_d;
    logic signed [SW-1:0] sr_d;
    logic signed [SW-1:0] si_d;

    logic signed [SW-1:0] sr_q;
    logic signed [SW-1:0] si_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 valid_q;

    logic signed [PW-1:0] prod_r;
    logic signed [PW-1:0] prod_i;
    logic signed [PW-1:0] adj_r;
    logic signed [PW-1:0] adj_i;
    logic                 unused_frac;

    // Stage 1: sr = s_r*rx_r + s_i*rx_i, si = s_r*rx_i - s_i*rx_r
    always_comb begin
        sgn_r  = pilot_sign_t'(nrs_r);
        sgn_i  = pilot_sign_t'(nrs_i);
        xr     = {{2{rx_r[WIDTH_R_I-1]}}, rx_r};
        xi     = {{2{rx_i[WIDTH_R_I-1]}}, rx_i};
        term_a = (sgn_r == SIGN_NEG) ? -xr : xr;
        term_b = (sgn_i == SIGN_NEG) ? -xi : xi;
        term_c = (sgn_r == SIGN_NEG) ? -xi : xi;
        term_d = (sgn_i == SIGN_NEG) ? -xr : xr;
        sr_d   = term_a + term_b;
        si_d   = term_c - term_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            si_q    <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                sr_q   <= sr_d;
                si_q   <= si_d;
                addr_q <= wr_addr;
            end
        end
    end

    // Stage 2: scale and drop fraction bits (arithmetic shift = floor)
    always_comb begin
        prod_r = PW'(sr_q) * SCALE;
        prod_i = PW'(si_q) * SCALE;
`ifdef CMPLX_MULT_ROUND_EN
        adj_r  = prod_r + (PW'(1) <<< (PILOT_FLOAT_BITS - 1));
        adj_i  = prod_i + (PW'(1) <<< (PILOT_FLOAT_BITS - 1));
`else
        adj_r  = prod_r;
        adj_i  = prod_i;
`endif
        out_r  = adj_r[PW-1:PILOT_FLOAT_BITS];
        out_i  = adj_i[PW-1:PILOT_FLOAT_BITS];
    end

    // Fraction bits are intentionally discarded.
    assign unused_frac = ^{adj_r[PILOT_FLOAT_BITS-1:0], adj_i[PILOT_FLOAT_BITS-1:0]};

    assign out_valid = valid_q;
    assign out_addr  = addr_q;

endmodule

// File: rtl/nrs_cmplx_mult_bank.sv
// ---------------------------------------------------------------------------
// nrs_cmplx_mult_bank
// LS channel-estimate stage: multiplies each received NRS sample by the
// conjugate QPSK pilot, stores the result in a DEPTH-entry estimate bank and
// serves registered reads to the interpolator.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en, wr_addr           sample valid and destination entry
//   rx_r, rx_i            signed received sample (WIDTH_R_I)
//   nrs_r, nrs_i          pilot sign per axis (0 = +VALUE, 1 = -VALUE)
//   clr                   invalidate whole bank and flush in-flight writes
//   rd_en, rd_addr        read request
//   real_part, imag_part  registered read data (WIDTH_R_I+1 signed)
//   rd_valid              read hit a valid entry (one-cycle pulse)
//   entry_valid           per-entry valid bitmap
//   all_valid             every entry valid
// Write latency is two edges (capture, then bank write). Reads see the bank
// state before the same edge's write (no bypass).
// Configuration macro: CMPLX_MULT_ROUND_EN (round-half-up scaling, handled
// inside cmplx_sign_mac).
// ---------------------------------------------------------------------------
module nrs_cmplx_mult_bank
    import nb_iot_ce_pkg::*;
#(
    parameter int                          WIDTH_R_I        = CE_WIDTH_R_I,
    parameter int                          PILOT_FLOAT_BITS = CE_PILOT_FLOAT_BITS,
    parameter logic [PILOT_FLOAT_BITS-1:0] VALUE            = INV_SQRT2,
    parameter int                          DEPTH            = 4,
    localparam int                         ADDR_W           = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic signed [WIDTH_R_I-1:0] rx_r,
    input  logic signed [WIDTH_R_I-1:0] rx_i,
    input  logic                        nrs_r,
    input  logic                        nrs_i,
    input  logic                        clr,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic signed [WIDTH_R_I:0]   real_part,
    output logic signed [WIDTH_R_I:0]   imag_part,
    output logic                        rd_valid,
    output logic [DEPTH-1:0]            entry_valid,
    output logic                        all_valid
);

    logic                      s2_valid;
    logic [ADDR_W-1:0]         s2_addr;
    logic signed [WIDTH_R_I:0] s2_r;
    logic signed [WIDTH_R_I:0] s2_i;
    logic                      wr_fire;

    logic signed [WIDTH_R_I:0] bank_r [DEPTH];
    logic signed [WIDTH_R_I:0] bank_i [DEPTH];

    cmplx_sign_mac #(
        .WIDTH_R_I        (WIDTH_R_I),
        .PILOT_FLOAT_BITS (PILOT_FLOAT_BITS),
        .VALUE            (VALUE),
        .ADDR_W           (ADDR_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_addr   (wr_addr),
        .rx_r      (rx_r),
        .rx_i      (rx_i),
        .nrs_r     (nrs_r),
        .nrs_i     (nrs_i),
        .out_valid (s2_valid),
        .out_addr  (s2_addr),
        .out_r     (s2_r),
        .out_i     (s2_i)
    );

    // clr and rst both kill the sample currently leaving stage 1; a sample
    // captured on the clr edge itself survives into the new frame.
    always_comb begin
        wr_fire = s2_valid && !clr && !rst;
    end

    // Bank storage carries no reset; validity lives in entry_valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_r[s2_addr] <= s2_r;
            bank_i[s2_addr] <= s2_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid <= '0;
        end else if (clr) begin
            entry_valid <= '0;
        end else if (wr_fire) begin
            entry_valid[s2_addr] <= 1'b1;
        end
    end

    always_comb begin
        all_valid = &entry_valid;
    end

    // Registered read: sees pre-edge bank contents and valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            real_part <= '0;
            imag_part <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en && entry_valid[rd_addr];
            if (rd_en) begin
                real_part <= bank_r[rd_addr];
                imag_part <= bank_i[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_nrs_cmplx_mult_bank.sv
module tb_nrs_cmplx_mult_bank;
    import nb_iot_ce_pkg::*;

    logic               clk;
    logic               rst;
    logic               en;
    logic [1:0]         wr_addr;
    sample_t            rx_r;
    sample_t            rx_i;
    logic               nrs_r;
    logic               nrs_i;
    logic               clr;
    logic               rd_en;
    logic [1:0]         rd_addr;
    logic signed [16:0] real_part;
    logic signed [16:0] imag_part;
    logic               rd_valid;
    logic [3:0]         entry_valid;
    logic               all_valid;

    int n_vec;
    int n_err;

    // Hand-computed expectations, VALUE = 1448, 11 fraction bits.
    // A: rx=(1000,0)        nrs=(0,0) -> sr=1000,  si=-1000
    // B: rx=(-32768,-32768) nrs=(1,1) -> sr=65536, si=0
    // C: rx=(300,-500)      nrs=(0,1) -> sr=800,   si=-200
    // D: rx=(12345,6789)    nrs=(1,0) -> sr=-5556, si=-19134
    // E: rx=(32767,-32768)  nrs=(0,0) -> sr=-1,    si=-65535
`ifdef CMPLX_MULT_ROUND_EN
    localparam logic signed [16:0] A_R = 707,    A_I = -707;
    localparam logic signed [16:0] C_R = 566,    C_I = -141;
    localparam logic signed [16:0] D_R = -3928,  D_I = -13528;
    localparam logic signed [16:0] E_R = -1,     E_I = -46335;
`else
    localparam logic signed [16:0] A_R = 707,    A_I = -708;
    localparam logic signed [16:0] C_R = 565,    C_I = -142;
    localparam logic signed [16:0] D_R = -3929,  D_I = -13529;
    localparam logic signed [16:0] E_R = -1,     E_I = -46336;
`endif
    localparam logic signed [16:0] B_R = 46336,  B_I = 0;

    nrs_cmplx_mult_bank #(
        .WIDTH_R_I        (16),
        .PILOT_FLOAT_BITS (11),
        .VALUE            (11'b10110101000),
        .DEPTH            (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_addr     (wr_addr),
        .rx_r        (rx_r),
        .rx_i        (rx_i),
        .nrs_r       (nrs_r),
        .nrs_i       (nrs_i),
        .clr         (clr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .real_part   (real_part),
        .imag_part   (imag_part),
        .rd_valid    (rd_valid),
        .entry_valid (entry_valid),
        .all_valid   (all_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input logic [1:0] a, input sample_t r, input sample_t i,
                              input logic nr, input logic ni);
        en      = 1'b1;
        wr_addr = a;
        rx_r    = r;
        rx_i    = i;
        nrs_r   = nr;
        nrs_i   = ni;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (real_part !== 17'sd0) begin n_err++; $display("FAIL reset_real: got %0d expected 0", real_part); end
        n_vec++; if (imag_part !== 17'sd0) begin n_err++; $display("FAIL reset_imag: got %0d expected 0", imag_part); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_vec++; if (entry_valid !== 4'b0000) begin n_err++; $display("FAIL reset_entry_valid: got %b expected 0000", entry_valid); end
        n_vec++; if (all_valid !== 1'b0) begin n_err++; $display("FAIL reset_all_valid: got %b expected 0", all_valid); end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        set_sample(2'd0, 16'sd1000, 16'sd0, 1'b0, 1'b0);
        step();
        en = 1'b0;
        n_vec++; if (entry_valid !== 4'b0000) begin n_err++; $display("FAIL single_latency1: entry_valid got %b expected 0000", entry_valid); end
        step();
        n_vec++; if (entry_valid !== 4'b0001) begin n_err++; $display("FAIL single_latency2: entry_valid got %b expected 0001", entry_valid); end
        rd_en   = 1'b1;
        rd_addr = 2'd0;
        step();
        rd_en = 1'b0;
        n_vec++; if (real_part !== A_R) begin n_err++; $display("FAIL single_real: got %0d expected %0d", real_part, A_R); end
        n_vec++; if (imag_part !== A_I) begin n_err++; $display("FAIL single_imag: got %0d expected %0d", imag_part, A_I); end
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL single_rd_valid: got %b expected 1", rd_valid); end
        step();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_rd_pulse: got %b expected 0", rd_valid); end
        n_vec++; if (real_part !== A_R) begin n_err++; $display("FAIL single_hold: got %0d expected %0d", real_part, A_R); end
    endtask

    task automatic test_back_to_back();
        logic signed [16:0] er [4];
        logic signed [16:0] ei [4];
        er[0] = C_R; ei[0] = C_I;
        er[1] = D_R; ei[1] = D_I;
        er[2] = E_R; ei[2] = E_I;
        er[3] = B_R; ei[3] = B_I;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_vec++; if (entry_valid !== 4'b0000) begin n_err++; $display("FAIL b2b_clr: entry_valid got %b expected 0000", entry_valid); end
        set_sample(2'd0, 16'sd300, -16'sd500, 1'b0, 1'b1);
        step();
        set_sample(2'd1, 16'sd12345, 16'sd6789, 1'b1, 1'b0);
        step();
        set_sample(2'd2, 16'sd32767, -16'sd32768, 1'b0, 1'b0);
        step();
        set_sample(2'd3, -16'sd32768, -16'sd32768, 1'b1, 1'b1);
        step();
        en = 1'b0;
        n_vec++; if (entry_valid !== 4'b0111) begin n_err++; $display("FAIL b2b_partial: entry_valid got %b expected 0111", entry_valid); end
        n_vec++; if (all_valid !== 1'b0) begin n_err++; $display("FAIL b2b_all_early: got %b expected 0", all_valid); end
        step();
        n_vec++; if (entry_valid !== 4'b1111) begin n_err++; $display("FAIL b2b_full: entry_valid got %b expected 1111", entry_valid); end
        n_vec++; if (all_valid !== 1'b1) begin n_err++; $display("FAIL b2b_all: got %b expected 1", all_valid); end
        rd_en = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            step();
            n_vec++; if (real_part !== er[k]) begin n_err++; $display("FAIL b2b_real[%0d]: got %0d expected %0d", k, real_part, er[k]); end
            n_vec++; if (imag_part !== ei[k]) begin n_err++; $display("FAIL b2b_imag[%0d]: got %0d expected %0d", k, imag_part, ei[k]); end
            n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd_valid[%0d]: got %b expected 1", k, rd_valid); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_same_addr();
        set_sample(2'd1, 16'sd1000, 16'sd0, 1'b0, 1'b0);
        step();
        set_sample(2'd1, 16'sd300, -16'sd500, 1'b0, 1'b1);
        step();
        en = 1'b0;
        step();
        rd_en   = 1'b1;
        rd_addr = 2'd1;
        step();
        rd_en = 1'b0;
        n_vec++; if (real_part !== C_R) begin n_err++; $display("FAIL same_addr_real: got %0d expected %0d", real_part, C_R); end
        n_vec++; if (imag_part !== C_I) begin n_err++; $display("FAIL same_addr_imag: got %0d expected %0d", imag_part, C_I); end
    endtask

    task automatic test_read_during_write();
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_sample(2'd2, 16'sd1000, 16'sd0, 1'b0, 1'b0);
        step();
        en      = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 2'd2;
        step();
        n_vec++; if (real_part !== E_R) begin n_err++; $display("FAIL rdw_old_real: got %0d expected %0d", real_part, E_R); end
        n_vec++; if (imag_part !== E_I) begin n_err++; $display("FAIL rdw_old_imag: got %0d expected %0d", imag_part, E_I); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rdw_old_valid: got %b expected 0", rd_valid); end
        n_vec++; if (entry_valid !== 4'b0100) begin n_err++; $display("FAIL rdw_entry_valid: got %b expected 0100", entry_valid); end
        step();
        rd_en = 1'b0;
        n_vec++; if (real_part !== A_R) begin n_err++; $display("FAIL rdw_new_real: got %0d expected %0d", real_part, A_R); end
        n_vec++; if (imag_part !== A_I) begin n_err++; $display("FAIL rdw_new_imag: got %0d expected %0d", imag_part, A_I); end
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rdw_new_valid: got %b expected 1", rd_valid); end
    endtask

    task automatic test_clr_flush();
        set_sample(2'd3, 16'sd300, -16'sd500, 1'b0, 1'b1);
        step();
        set_sample(2'd1, 16'sd12345, 16'sd6789, 1'b1, 1'b0);
        clr = 1'b1;
        step();
        en  = 1'b0;
        clr = 1'b0;
        n_vec++; if (entry_valid !== 4'b0000) begin n_err++; $display("FAIL clr_flush: entry_valid got %b expected 0000", entry_valid); end
        step();
        n_vec++; if (entry_valid !== 4'b0010) begin n_err++; $display("FAIL clr_new_frame: entry_valid got %b expected 0010", entry_valid); end
        rd_en   = 1'b1;
        rd_addr = 2'd3;
        step();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_dropped_read: rd_valid got %b expected 0", rd_valid); end
        rd_addr = 2'd1;
        step();
        rd_en = 1'b0;
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL clr_kept_valid: got %b expected 1", rd_valid); end
        n_vec++; if (real_part !== D_R) begin n_err++; $display("FAIL clr_kept_real: got %0d expected %0d", real_part, D_R); end
        n_vec++; if (imag_part !== D_I) begin n_err++; $display("FAIL clr_kept_imag: got %0d expected %0d", imag_part, D_I); end
    endtask

    task automatic test_rst_midstream();
        rd_en   = 1'b1;
        rd_addr = 2'd1;
        set_sample(2'd2, 16'sd300, -16'sd500, 1'b0, 1'b1);
        step();
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b expected 1", rd_valid); end
        en    = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if (real_part !== 17'sd0) begin n_err++; $display("FAIL rst_mid_real: got %0d expected 0", real_part); end
        n_vec++; if (imag_part !== 17'sd0) begin n_err++; $display("FAIL rst_mid_imag: got %0d expected 0", imag_part); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_rd_valid: got %b expected 0", rd_valid); end
        n_vec++; if (entry_valid !== 4'b0000) begin n_err++; $display("FAIL rst_mid_entry_valid: got %b expected 0000", entry_valid); end
        step();
        n_vec++; if (entry_valid !== 4'b0000) begin n_err++; $display("FAIL rst_dropped: entry_valid got %b expected 0000", entry_valid); end
        rd_en   = 1'b1;
        rd_addr = 2'd2;
        step();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_read2: rd_valid got %b expected 0", rd_valid); end
        rd_addr = 2'd1;
        step();
        rd_en = 1'b0;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_read1: rd_valid got %b expected 0", rd_valid); end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        rd_en   = 1'b0;
        wr_addr = 2'd0;
        rd_addr = 2'd0;
        rx_r    = '0;
        rx_i    = '0;
        nrs_r   = 1'b0;
        nrs_i   = 1'b0;

        test_reset();
        test_single_write();
        test_back_to_back();
        test_same_addr();
        test_read_during_write();
        test_clr_flush();
        test_rst_midstream();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
